// File: rtl/spi_baud_gen.sv
// SPI master baud-rate generator: BaudRate = clk / ((SPPR+1) * 2^(SPR+1)), 50% duty.
// Define SPI_BRG_STROBE_EN to get the BR_rise/BR_fall edge strobes; otherwise they are tied low.
module spi_baud_gen #(
    parameter int unsigned PRE_W = 3,
    parameter int unsigned SPR_W = 3,
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             BRG_clr,
    input  logic [PRE_W-1:0] SPPR,
    input  logic [SPR_W-1:0] SPR,
    output logic             BaudRate,
    output logic             BR_rise,
    output logic             BR_fall
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOW   = 2'd1,
        HIGH  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] sppr_q, sppr_d;
    logic [SPR_W-1:0] spr_q, spr_d;
    logic             baud_d;
    logic             load_c;
    logic [CNT_W-1:0] half_c;
    logic [CNT_W-1:0] last_c;
    logic             term_c;
`ifdef SPI_BRG_STROBE_EN
    logic             rise_c;
    logic             fall_c;
`endif

    // Half period from the shadowed rate selects; only these copies affect timing
    assign half_c = (CNT_W'(sppr_q) + CNT_W'(1)) << spr_q;
    assign last_c = half_c - CNT_W'(1);
    assign term_c = (cnt_q == last_c);

    // Next-state, counter and shadow-load decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        baud_d  = BaudRate;
        load_c  = 1'b0;
`ifdef SPI_BRG_STROBE_EN
        rise_c  = 1'b0;
        fall_c  = 1'b0;
`endif
        case (state_q)
            CLEAR: begin
                load_c = 1'b1;
                cnt_d  = '0;
                baud_d = 1'b0;
                if (!BRG_clr) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (BRG_clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    baud_d  = 1'b0;
                end else if (term_c) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    baud_d  = 1'b1;
`ifdef SPI_BRG_STROBE_EN
                    rise_c  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (BRG_clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    baud_d  = 1'b0;
                end else if (term_c) begin
                    // Rate changes take effect only here, so no half-period is ever distorted
                    state_d = LOW;
                    cnt_d   = '0;
                    baud_d  = 1'b0;
                    load_c  = 1'b1;
`ifdef SPI_BRG_STROBE_EN
                    fall_c  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
                baud_d  = 1'b0;
            end
        endcase
        sppr_d = load_c ? SPPR : sppr_q;
        spr_d  = load_c ? SPR  : spr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            BaudRate <= 1'b0;
            sppr_q   <= '0;
            spr_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            BaudRate <= baud_d;
            sppr_q   <= sppr_d;
            spr_q    <= spr_d;
        end
    end

`ifdef SPI_BRG_STROBE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            BR_rise <= 1'b0;
            BR_fall <= 1'b0;
        end else begin
            BR_rise <= rise_c;
            BR_fall <= fall_c;
        end
    end
`else
    assign BR_rise = 1'b0;
    assign BR_fall = 1'b0;
`endif

endmodule
